// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequencing controller for a bit-serial adder datapath.
// Accepts an operand pair, loads the PISOs, shifts WIDTH sum bits plus one
// carry bit into the SIPO, then presents the captured {carry, sum} result.
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds the signed overflow flag
// output ovf).
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             piso_load,
    output logic [WIDTH-1:0] piso_a,
    output logic [WIDTH-1:0] piso_b,
    output logic             shift_en,
    output logic             carry_clr,
    output logic             sipo_clr,
    output logic             sipo_en,
    output logic             carry_sel,
    input  logic [WIDTH:0]   res_in,
    output logic             busy,
    output logic [4:0]       bit_cnt
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CARRY,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);
    localparam logic [4:0] CNT_FULL = 5'(WIDTH);

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH:0]   result_q, result_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // State, shift counter, latched operands and captured result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Next-state logic: sequence the operation and capture the SIPO result
    // on the SETTLE -> DONE transition.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    opa_d   = op_a;
                    opb_d   = op_b;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_FULL;
                    state_d = S_CARRY;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_CARRY: begin
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                result_d = res_in;
`ifdef SERIAL_ADDER_OVF_EN
                ovf_d    = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                           (res_in[WIDTH-1] != opa_q[WIDTH-1]);
`endif
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d = 1'b0;
`endif
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath strobes and handshake outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        piso_load = 1'b0;
        shift_en  = 1'b0;
        carry_clr = 1'b0;
        sipo_clr  = 1'b0;
        sipo_en   = 1'b0;
        carry_sel = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_LOAD: begin
                piso_load = 1'b1;
                carry_clr = 1'b1;
                sipo_clr  = 1'b1;
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                sipo_en  = 1'b1;
            end
            S_CARRY: begin
                sipo_en   = 1'b1;
                carry_sel = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign bit_cnt = cnt_q;
    assign piso_a  = opa_q;
    assign piso_b  = opb_q;
    assign result  = result_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: drives serial_adder_ctrl with a behavioural bit-serial
// datapath attached and compares results against integer addition.
// Optional feature macro: SERIAL_ADDER_OVF_EN (also checks ovf).
module tb_serial_adder_ctrl;

    localparam int W = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   result;
    logic         piso_load;
    logic [W-1:0] piso_a;
    logic [W-1:0] piso_b;
    logic         shift_en;
    logic         carry_clr;
    logic         sipo_clr;
    logic         sipo_en;
    logic         carry_sel;
    logic [W:0]   res_in;
    logic         busy;
    logic [4:0]   bit_cnt;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .piso_load (piso_load),
        .piso_a    (piso_a),
        .piso_b    (piso_b),
        .shift_en  (shift_en),
        .carry_clr (carry_clr),
        .sipo_clr  (sipo_clr),
        .sipo_en   (sipo_en),
        .carry_sel (carry_sel),
        .res_in    (res_in),
        .busy      (busy),
        .bit_cnt   (bit_cnt)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial datapath attached to the controller: two PISOs, full adder,
    // carry flop and SIPO shifting in at the MSB end.
    logic [W-1:0] pa, pb;
    logic         cq;
    logic [W:0]   sipo;
    logic         fa_sum, fa_cout;
    assign fa_sum  = pa[0] ^ pb[0] ^ cq;
    assign fa_cout = (pa[0] & pb[0]) | (pa[0] & cq) | (pb[0] & cq);
    assign res_in  = sipo;

    always @(posedge clk) begin
        if (piso_load) begin
            pa <= piso_a;
            pb <= piso_b;
        end else if (shift_en) begin
            pa <= pa >> 1;
            pb <= pb >> 1;
        end
        if (carry_clr) cq <= 1'b0;
        else if (shift_en) cq <= fa_cout;
        if (sipo_clr) sipo <= '0;
        else if (sipo_en) sipo <= {(carry_sel ? cq : fa_sum), sipo[W:1]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_ovf(input int a, input int b);
        int sa, sb, s;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        s  = sa + sb;
        return ((s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)))) ? 1 : 0;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  in_ready, 1);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_strobes"},
              {piso_load, shift_en, carry_clr, sipo_clr, sipo_en, carry_sel}, 0);
    endtask

    // One full transaction: accept, watch strobes, check result and handshake.
    task automatic run_op(input int a, input int b, input int hold, input bit preready);
        int waited, edges, nload, nshift, nsipo, ncarry, carry_at, bad;
        logic [W:0] exp_res;
        exp_res = (W + 1)'(a + b);
        waited  = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check("in_ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        op_a      = W'(a);
        op_b      = W'(b);
        out_ready = preready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a     = W'($urandom);
        op_b     = W'($urandom);
        edges = 0; nload = 0; nshift = 0; nsipo = 0; ncarry = 0; carry_at = -1; bad = 0;
        while (!out_valid && edges < 40) begin
            if (piso_load) begin
                nload++;
                check("piso_a", piso_a, a);
                check("piso_b", piso_b, b);
                check("bit_cnt_load", bit_cnt, 0);
            end
            if (shift_en) begin
                nshift++;
                check("bit_cnt_shift", bit_cnt, edges - 1);
            end
            if (sipo_en) nsipo++;
            if (carry_sel) begin
                ncarry++;
                carry_at = edges;
                check("bit_cnt_carry", bit_cnt, W);
            end
            if (shift_en && !sipo_en) bad++;
            if (carry_sel && (piso_load || shift_en || !sipo_en)) bad++;
            @(posedge clk); #1;
            edges++;
        end
        check("latency", edges, W + 3);
        check("piso_load_cycles", nload, 1);
        check("shift_en_cycles", nshift, W);
        check("sipo_en_cycles", nsipo, W + 1);
        check("carry_sel_cycles", ncarry, 1);
        check("carry_sel_pos", carry_at, W + 1);
        check("strobe_consistency", bad, 0);
        check("result", result, exp_res);
        check("in_ready_done", in_ready, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", ovf, ref_ovf(a, b));
`endif
        if (!preready) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                op_a     = W'($urandom);
                op_b     = W'($urandom);
                @(posedge clk); #1;
                check("bp_out_valid", out_valid, 1);
                check("bp_result", result, exp_res);
                check("bp_in_ready", in_ready, 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_idle("after_handshake");
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf_cleared", ovf, 0);
`endif
    endtask

    initial begin
        int waited, seen;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_result", result, 0);
        check("reset_bit_cnt", bit_cnt, 0);
        check("reset_piso_a", piso_a, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle("post_reset");

        run_op(8'h5A, 8'h3C, 0, 1'b0);
        run_op(8'hFF, 8'h01, 0, 1'b0);
        run_op(8'h7F, 8'h01, 0, 1'b1);
        run_op(8'h80, 8'h80, 0, 1'b0);
        run_op(8'h5A, 8'h3C, 5, 1'b0);
        run_op(8'h00, 8'h00, 1, 1'b0);
        for (int n = 0; n < 20; n++) begin
            run_op(int'($urandom) & MASK, int'($urandom) & MASK,
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Abort in the middle of shifting.
        in_valid = 1'b1;
        op_a     = 8'h33;
        op_b     = 8'h44;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waited   = 0;
        while (!(shift_en && bit_cnt == 5'd3) && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("reach_bit_cnt_3", bit_cnt, 3);
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle("mid_shift_reset");
        check("mid_shift_bit_cnt", bit_cnt, 0);
        rst  = 1'b1;
        seen = 0;
        repeat (W + 5) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("no_out_valid_after_abort", seen, 0);
        run_op(8'h01, 8'h02, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
